// File: rtl/count_fifo_bundle.sv
// count_fifo_bundle: three independent utilities sharing one clock/reset.
//   - Modulo-Threshold alarm counter (round-robin turn selection)
//   - CtrWidth up counter with clear/set/load/enable (work tracking)
//   - Buffering-deep first-word-fall-through FIFO (header buffering)
// Ports:
//   Clock, Reset            rising-edge clock, synchronous active-low reset
//   AlarmEnable             advance alarm counter
//   AlarmCount, AlarmDone   alarm value; Done = Enable && Count==Threshold-1
//   CtrClear/Set/Load/Enable, CtrIn, CtrCount   general counter
//   InData, InValid, InAccept                   FIFO write side
//   OutData, OutSend, OutReady                  FIFO read side (FWFT)
module count_fifo_bundle #(
  parameter int Threshold = 2,
  parameter int CtrWidth  = 8,
  parameter int FIFOWidth = 64,
  parameter int Buffering = 2,
  localparam int AWidth   = (Threshold > 2) ? $clog2(Threshold) : 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 AlarmEnable,
  output logic [AWidth-1:0]    AlarmCount,
  output logic                 AlarmDone,
  input  logic                 CtrClear,
  input  logic                 CtrSet,
  input  logic                 CtrLoad,
  input  logic                 CtrEnable,
  input  logic [CtrWidth-1:0]  CtrIn,
  output logic [CtrWidth-1:0]  CtrCount,
  input  logic [FIFOWidth-1:0] InData,
  input  logic                 InValid,
  output logic                 InAccept,
  output logic [FIFOWidth-1:0] OutData,
  output logic                 OutSend,
  input  logic                 OutReady
);

  localparam int PWidth = (Buffering > 1) ? $clog2(Buffering) : 1;
  localparam int OWidth = $clog2(Buffering + 1);

  // Alarm counter: explicit wrap so non-power-of-two moduli work.
  logic alarmAtTop;
  assign alarmAtTop = (AlarmCount == AWidth'(Threshold - 1));
  assign AlarmDone  = AlarmEnable && alarmAtTop;

  always_ff @(posedge Clock) begin
    if (!Reset)           AlarmCount <= '0;
    else if (AlarmEnable) AlarmCount <= alarmAtTop ? '0 : AlarmCount + AWidth'(1);
  end

  // General counter: clear > set > load > enable. CtrIn only reaches the
  // register on the load branch, so unknowns on it stay contained.
  always_ff @(posedge Clock) begin
    if (!Reset)         CtrCount <= '0;
    else if (CtrClear)  CtrCount <= '0;
    else if (CtrSet)    CtrCount <= '1;
    else if (CtrLoad)   CtrCount <= CtrIn;
    else if (CtrEnable) CtrCount <= CtrCount + CtrWidth'(1);
  end

  // FIFO
  logic [FIFOWidth-1:0] mem [Buffering];
  logic [PWidth-1:0]    wrPtr, rdPtr;
  logic [OWidth-1:0]    occ;
  logic                 push, pop;

  assign InAccept = (occ < OWidth'(Buffering));
  assign OutSend  = (occ != '0);
  assign push     = InValid && InAccept;
  assign pop      = OutSend && OutReady;
  assign OutData  = mem[rdPtr];

  function automatic logic [PWidth-1:0] nextPtr(input logic [PWidth-1:0] p);
    return (p == PWidth'(Buffering - 1)) ? '0 : p + PWidth'(1);
  endfunction

  // Storage needs no reset: pointers and occupancy define what is valid.
  always_ff @(posedge Clock) begin
    if (push) mem[wrPtr] <= InData;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      occ   <= '0;
    end else begin
      if (push) wrPtr <= nextPtr(wrPtr);
      if (pop)  rdPtr <= nextPtr(rdPtr);
      case ({push, pop})
        2'b10:   occ <= occ + OWidth'(1);
        2'b01:   occ <= occ - OWidth'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_count_fifo_bundle.sv
module tb_count_fifo_bundle;

  logic Clock = 0;
  logic Reset;
  always #5 Clock = ~Clock;

  // DUT A: Threshold=3, Buffering=2
  logic        ae, clr, set, ld, en, iv, rdy;
  logic [7:0]  cin;
  logic [63:0] din;
  logic [1:0]  aCnt;
  logic        aDone, acc, send;
  logic [7:0]  cCnt;
  logic [63:0] dout;

  count_fifo_bundle #(.Threshold(3), .CtrWidth(8), .FIFOWidth(64), .Buffering(2)) dut (
    .Clock(Clock), .Reset(Reset),
    .AlarmEnable(ae), .AlarmCount(aCnt), .AlarmDone(aDone),
    .CtrClear(clr), .CtrSet(set), .CtrLoad(ld), .CtrEnable(en), .CtrIn(cin), .CtrCount(cCnt),
    .InData(din), .InValid(iv), .InAccept(acc),
    .OutData(dout), .OutSend(send), .OutReady(rdy)
  );

  // DUT B: Buffering=3 for non-power-of-two pointer wrap
  logic       bIV, bRdy, bAccept, bSend, bADone;
  logic [7:0] bIn, bOut, bCnt;
  logic       bAe = 0, bClr = 0, bSet = 0, bLd = 0, bEn = 0;
  logic [7:0] bCin = 0;
  logic [0:0] bACnt;

  count_fifo_bundle #(.Threshold(2), .CtrWidth(8), .FIFOWidth(8), .Buffering(3)) dutB (
    .Clock(Clock), .Reset(Reset),
    .AlarmEnable(bAe), .AlarmCount(bACnt), .AlarmDone(bADone),
    .CtrClear(bClr), .CtrSet(bSet), .CtrLoad(bLd), .CtrEnable(bEn), .CtrIn(bCin), .CtrCount(bCnt),
    .InData(bIn), .InValid(bIV), .InAccept(bAccept),
    .OutData(bOut), .OutSend(bSend), .OutReady(bRdy)
  );

  int total = 0, passed = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    else passed++;
  endfunction

  typedef struct {
    logic ae, clr, set, ld, en;
    logic [7:0] cin;
    logic [63:0] din;
    logic iv, rdy;
    logic eDone;          // AlarmDone before the edge
    logic [1:0] eA;       // post-edge values
    logic [7:0] eC;
    logic eSend, eAcc;
    logic [63:0] eData;
  } vec_t;

  vec_t tv[13];

  initial begin
    //        ae clr set ld en cin     din   iv rdy  done eA eC     send acc data
    tv[0]  = '{1, 0, 0, 0, 1, 8'h00, 64'hA, 1, 0,   0,  1, 8'h01, 1, 1, 64'hA};
    tv[1]  = '{1, 0, 0, 0, 1, 8'h00, 64'hB, 1, 0,   0,  2, 8'h02, 1, 0, 64'hA};
    tv[2]  = '{1, 0, 0, 0, 1, 8'h00, 64'hC, 1, 0,   1,  0, 8'h03, 1, 0, 64'hA};
    tv[3]  = '{1, 0, 0, 0, 1, 8'h00, 64'h0, 0, 1,   0,  1, 8'h04, 1, 1, 64'hB};
    tv[4]  = '{1, 0, 0, 0, 1, 8'h00, 64'h0, 0, 1,   0,  2, 8'h05, 0, 1, 64'h0};
    tv[5]  = '{1, 0, 0, 1, 1, 8'hFE, 64'h0, 0, 1,   1,  0, 8'hFE, 0, 1, 64'h0};
    tv[6]  = '{1, 0, 0, 0, 1, 8'h00, 64'h1, 1, 0,   0,  1, 8'hFF, 1, 1, 64'h1};
    tv[7]  = '{0, 0, 0, 0, 1, 8'h00, 64'h2, 1, 1,   0,  1, 8'h00, 1, 1, 64'h2};
    tv[8]  = '{0, 0, 1, 0, 0, 8'h00, 64'h0, 0, 1,   0,  1, 8'hFF, 0, 1, 64'h0};
    tv[9]  = '{0, 1, 1, 0, 1, 8'h00, 64'h3, 1, 1,   0,  1, 8'h00, 1, 1, 64'h3};
    tv[10] = '{1, 0, 0, 0, 1, 8'hxx, 64'h4, 1, 0,   0,  2, 8'h01, 1, 0, 64'h3};
    tv[11] = '{1, 0, 0, 1, 0, 8'h33, 64'h0, 0, 0,   1,  0, 8'h33, 1, 0, 64'h3};
    tv[12] = '{1, 0, 0, 0, 0, 8'h00, 64'h0, 0, 0,   0,  1, 8'h33, 1, 0, 64'h3};

    Reset = 0;
    {ae, clr, set, ld, en, iv, rdy} = '0;
    cin = '0; din = '0; bIV = 0; bRdy = 0; bIn = '0;
    repeat (2) @(posedge Clock);
    #1;
    chk("rst_acnt", 64'(aCnt), 0);
    chk("rst_ctr", 64'(cCnt), 0);
    chk("rst_send", 64'(send), 0);
    chk("rst_acc", 64'(acc), 1);
    chk("rst_bsend", 64'(bSend), 0);

    @(negedge Clock);
    Reset = 1;
    for (int i = 0; i < 13; i++) begin
      @(negedge Clock);
      ae = tv[i].ae; clr = tv[i].clr; set = tv[i].set; ld = tv[i].ld; en = tv[i].en;
      cin = tv[i].cin; din = tv[i].din; iv = tv[i].iv; rdy = tv[i].rdy;
      #1;
      chk($sformatf("v%0d_done", i), 64'(aDone), 64'(tv[i].eDone));
      @(posedge Clock);
      #1;
      chk($sformatf("v%0d_acnt", i), 64'(aCnt), 64'(tv[i].eA));
      chk($sformatf("v%0d_ctr", i), 64'(cCnt), 64'(tv[i].eC));
      chk($sformatf("v%0d_send", i), 64'(send), 64'(tv[i].eSend));
      chk($sformatf("v%0d_acc", i), 64'(acc), 64'(tv[i].eAcc));
      if (tv[i].eSend) chk($sformatf("v%0d_data", i), dout, tv[i].eData);
    end

    // Reset mid-operation dominates all other inputs (FIFO full, ctr=0x33, alarm=1)
    @(negedge Clock);
    Reset = 0; ae = 1; en = 1; set = 1; ld = 0; clr = 0; iv = 1; din = 64'h99; rdy = 1;
    @(posedge Clock);
    #1;
    chk("mid_rst_acnt", 64'(aCnt), 0);
    chk("mid_rst_ctr", 64'(cCnt), 0);
    chk("mid_rst_send", 64'(send), 0);
    chk("mid_rst_acc", 64'(acc), 1);

    @(negedge Clock);
    Reset = 1; ae = 1; en = 0; set = 0; iv = 1; din = 64'h55; rdy = 0;
    @(posedge Clock);
    #1;
    chk("resume_acnt", 64'(aCnt), 1);
    chk("resume_ctr", 64'(cCnt), 0);
    chk("resume_send", 64'(send), 1);
    chk("resume_data", dout, 64'h55);
    @(negedge Clock);
    {ae, iv} = '0;

    // Streaming through a 3-deep FIFO: pointers wrap several times
    begin
      int nxt, got;
      nxt = 1; got = 0;
      for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
        @(negedge Clock);
        bIV  = (nxt <= 10);
        bIn  = 8'(nxt);
        bRdy = (cyc >= 4) && (cyc % 3 != 0);
        #1;
        if (bSend && bRdy) begin
          chk($sformatf("wrap_pop%0d", got), 64'(bOut), 64'(got + 1));
          got++;
        end
        if (bIV && bAccept) nxt++;
        @(posedge Clock);
      end
      @(negedge Clock);
      bIV = 0; bRdy = 0;
      chk("wrap_count", 64'(got), 10);
      chk("wrap_empty", 64'(bSend), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
